// File: rtl/div_const_pipe.sv
// Fully pipelined unsigned divide-by-constant: MSB-first radix-2^K recurrence using an elaboration-time digit table.
// Optional sideband tag carried alongside each result when DIV_CONST_TAG_EN is defined.
module div_const_pipe #(
    parameter int W = 32,
    parameter int D = 3,
    parameter int K = 4,
`ifdef DIV_CONST_TAG_EN
    parameter int TAG_W = 4,
`endif
    localparam int RW = $clog2(D),
    localparam int S  = (W + K - 1) / K
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_x,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_q,
    output logic [RW-1:0] out_r
`ifdef DIV_CONST_TAG_EN
    ,
    input  logic [TAG_W-1:0] in_tag,
    output logic [TAG_W-1:0] out_tag
`endif
);

    localparam int SK    = S * K;
    localparam int IW    = K + RW;
    localparam int TBL_N = D << K;

    // Table entry for v = r*2^K + c is {v / D, v % D}; index is simply {r, c}.
    logic [IW-1:0] tbl_s [TBL_N];

    for (genvar e = 0; e < TBL_N; e++) begin : g_tbl
        assign tbl_s[e] = {K'(e / D), RW'(e % D)};
    end

    // Stage 0 is the capture register; stages 1..S each retire one K-bit chunk.
    // acc holds the unconsumed dividend in its upper bits and the quotient digits
    // shifted in from the bottom, so after S stages it holds the full quotient.
    logic [S:0]    vld_q, vld_d;
    logic [SK-1:0] acc_q [0:S];
    logic [SK-1:0] acc_d [0:S];
    logic [RW-1:0] rem_q [0:S];
    logic [RW-1:0] rem_d [0:S];

    logic          out_valid_q;
    logic [W-1:0]  out_q_q;
    logic [RW-1:0] out_r_q;
    logic          stall_s;

    assign stall_s   = out_valid_q & ~out_ready;
    assign in_ready  = ~stall_s;
    assign out_valid = out_valid_q;
    assign out_q     = out_q_q;
    assign out_r     = out_r_q;

    assign vld_d[0] = in_valid;
    assign acc_d[0] = SK'(in_x);
    assign rem_d[0] = {RW{1'b0}};

    for (genvar i = 1; i <= S; i++) begin : g_stage
        logic [IW-1:0] ent_s;
        assign ent_s    = tbl_s[{rem_q[i-1], acc_q[i-1][SK-1 -: K]}];
        assign vld_d[i] = vld_q[i-1];
        assign acc_d[i] = (acc_q[i-1] << K) | SK'(ent_s[IW-1:RW]);
        assign rem_d[i] = ent_s[RW-1:0];
    end

    // Pipeline and output registers: everything advances together, or freezes on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= {(S+1){1'b0}};
            for (int i = 0; i <= S; i++) begin
                acc_q[i] <= {SK{1'b0}};
                rem_q[i] <= {RW{1'b0}};
            end
            out_valid_q <= 1'b0;
            out_q_q     <= {W{1'b0}};
            out_r_q     <= {RW{1'b0}};
        end else if (!stall_s) begin
            vld_q <= vld_d;
            for (int i = 0; i <= S; i++) begin
                acc_q[i] <= acc_d[i];
                rem_q[i] <= rem_d[i];
            end
            out_valid_q <= vld_q[S];
            out_q_q     <= acc_q[S][W-1:0];
            out_r_q     <= rem_q[S];
        end
    end

`ifdef DIV_CONST_TAG_EN
    logic [TAG_W-1:0] tag_q [0:S];
    logic [TAG_W-1:0] out_tag_q;

    assign out_tag = out_tag_q;

    // Tag shift chain under the same advance/stall control as the data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= S; i++) begin
                tag_q[i] <= {TAG_W{1'b0}};
            end
            out_tag_q <= {TAG_W{1'b0}};
        end else if (!stall_s) begin
            tag_q[0] <= in_tag;
            for (int i = 1; i <= S; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            out_tag_q <= tag_q[S];
        end
    end
`endif

endmodule
